// File: rtl/dpu_mac_seq_pkg.sv
// Shared types and constants for the INT8 MAC sequencer.
// Contents:
//   mac_seq_state_e : sequencer FSM state encoding
//   ACC_W           : accumulator / result width
//   DATA_W          : weight and activation operand width
package dpu_mac_seq_pkg;

    localparam int ACC_W  = 32;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } mac_seq_state_e;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Element counter and address generator for the MAC sequencer.
// Once loaded with a non-zero length, it holds the read strobe high for
// exactly that many consecutive cycles. Each cycle it steps both buffer
// addresses from their bases. Addresses wrap modulo 2**ADDR_W.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_load             start a sweep (caller guarantees i_len != 0)
//   i_len              element count
//   i_w_base/i_a_base  weight / activation base addresses
//   o_rd_en            read strobe shared by both buffers
//   o_w_addr/o_a_addr  current read addresses
//   o_last             strobe is on the final element of the sweep
module mac_seq_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [ADDR_W-1:0] i_w_base,
    input  logic [ADDR_W-1:0] i_a_base,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic [ADDR_W-1:0] o_a_addr,
    output logic              o_last
);

    logic              r_rd_en;
    logic [ADDR_W-1:0] r_w_addr;
    logic [ADDR_W-1:0] r_a_addr;
    logic [LEN_W-1:0]  r_remain;    // elements left after the current one

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en  <= 1'b0;
            r_w_addr <= '0;
            r_a_addr <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_rd_en  <= 1'b1;
            r_w_addr <= i_w_base;
            r_a_addr <= i_a_base;
            r_remain <= i_len - LEN_W'(1);
        end else if (r_rd_en) begin
            if (r_remain == '0) begin
                r_rd_en <= 1'b0;
            end else begin
                r_w_addr <= r_w_addr + ADDR_W'(1);
                r_a_addr <= r_a_addr + ADDR_W'(1);
                r_remain <= r_remain - LEN_W'(1);
            end
        end
    end

    assign o_rd_en  = r_rd_en;
    assign o_w_addr = r_w_addr;
    assign o_a_addr = r_a_addr;
    assign o_last   = r_rd_en && (r_remain == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one external INT8 MAC primitive.
// On start, it streams len weight/activation pairs from two synchronous-read
// buffers into the MAC at one pair per cycle and chains the 32-bit
// accumulator. The final dot product is returned over a valid/ready port.
// Optional feature macro: MAC_SEQ_BIAS_EN adds the i_bias port. The bias is
// latched with start and seeds the accumulator. Without the macro the seed
// is zero.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_start, i_len, i_w_base,
//   i_a_base, (i_bias)              job request, sampled only in IDLE
//   o_busy                          high outside IDLE
//   o_w_rd_en/o_w_rd_addr/i_w_rd_data   weight buffer read port
//   o_a_rd_en/o_a_rd_addr/i_a_rd_data   activation buffer read port
//   o_mac_valid, o_mac_weight, o_mac_activation, o_mac_acc_in   to MAC
//   i_mac_acc_out, i_mac_done                                   from MAC
//   o_res_valid, i_res_ready, o_res_data                        result port
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing buffer reads, one element per cycle
// DRAIN | waiting for the last MAC sum to come back
// OUT   | presenting the result until it is accepted
module mac_seq_ctrl
    import dpu_mac_seq_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    input  logic [ADDR_W-1:0]        i_w_base,
    input  logic [ADDR_W-1:0]        i_a_base,
`ifdef MAC_SEQ_BIAS_EN
    input  logic signed [ACC_W-1:0]  i_bias,
`endif
    output logic                     o_busy,
    output logic                     o_w_rd_en,
    output logic [ADDR_W-1:0]        o_w_rd_addr,
    input  logic signed [DATA_W-1:0] i_w_rd_data,
    output logic                     o_a_rd_en,
    output logic [ADDR_W-1:0]        o_a_rd_addr,
    input  logic signed [DATA_W-1:0] i_a_rd_data,
    output logic                     o_mac_valid,
    output logic signed [DATA_W-1:0] o_mac_weight,
    output logic signed [DATA_W-1:0] o_mac_activation,
    output logic signed [ACC_W-1:0]  o_mac_acc_in,
    input  logic signed [ACC_W-1:0]  i_mac_acc_out,
    input  logic                     i_mac_done,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic signed [ACC_W-1:0]  o_res_data
);

    mac_seq_state_e r_state;
    mac_seq_state_e w_next_state;

    logic                    w_accept;
    logic                    w_len_zero;
    logic                    w_rd_en;
    logic                    w_last;
    logic                    w_final_done;
    logic signed [ACC_W-1:0] w_init_in;

    logic                    r_mac_valid;
    logic                    r_mac_last;
    logic                    r_done_last;
    logic                    r_first_pending;
    logic signed [ACC_W-1:0] r_init;
    logic signed [ACC_W-1:0] r_res_data;

`ifdef MAC_SEQ_BIAS_EN
    assign w_init_in = i_bias;
`else
    assign w_init_in = '0;
`endif

    assign w_accept     = (r_state == IDLE) && i_start;
    assign w_len_zero   = (i_len == '0);
    // The MAC returns a sum for every element, so the sum is tagged to
    // recognise the one that belongs to the last element.
    assign w_final_done = i_mac_done && r_done_last;

    mac_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept && !w_len_zero),
        .i_len    (i_len),
        .i_w_base (i_w_base),
        .i_a_base (i_a_base),
        .o_rd_en  (w_rd_en),
        .o_w_addr (o_w_rd_addr),
        .o_a_addr (o_a_rd_addr),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = w_len_zero ? OUT : RUN;
            RUN:     if (w_last) w_next_state = DRAIN;
            DRAIN:   if (w_final_done) w_next_state = OUT;
            OUT:     if (i_res_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_valid     <= 1'b0;
            r_mac_last      <= 1'b0;
            r_done_last     <= 1'b0;
            r_first_pending <= 1'b1;
            r_init          <= '0;
            r_res_data      <= '0;
        end else begin
            r_mac_valid <= w_rd_en;
            r_mac_last  <= w_last;
            r_done_last <= r_mac_last;
            if (w_accept) begin
                r_init          <= w_init_in;
                r_first_pending <= 1'b1;
            end else if (r_mac_valid) begin
                r_first_pending <= 1'b0;
            end
            if (w_accept && w_len_zero) begin
                r_res_data <= w_init_in;
            end else if ((r_state == DRAIN) && w_final_done) begin
                r_res_data <= i_mac_acc_out;
            end
        end
    end

    assign o_busy           = (r_state != IDLE);
    assign o_w_rd_en        = w_rd_en;
    assign o_a_rd_en        = w_rd_en;
    assign o_mac_valid      = r_mac_valid;
    assign o_mac_weight     = i_w_rd_data;
    assign o_mac_activation = i_a_rd_data;
    // The first element of a job is seeded with the init value. Every later
    // element chains the sum the MAC registered on the previous cycle.
    assign o_mac_acc_in     = r_first_pending ? r_init : i_mac_acc_out;
    assign o_res_valid      = (r_state == OUT);
    assign o_res_data       = r_res_data;

endmodule
